dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port data memory between NUM_CORES processor cores.
- Each core presents an address (its AR value), write data and write enable, then holds its request.
- The arbiter serialises accesses, drives the memory port, returns read data, and pulses a per-core ack.
- Sits at the multi-core top level, between the core array and the shared DM.

Parameters:
- NUM_CORES, 4, number of requesting cores (1..8).
- AW, 16, address width; matches the core address register.
- DW, 16, data width; matches the core bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_CORES  per-core access request, level, held until ack.
- we  in  NUM_CORES  per-core write flag (1=write, 0=read); valid while req is high.
- addr  in  NUM_CORES*AW  packed per-core address; core i at [i*AW +: AW].
- wdata  in  NUM_CORES*DW  packed per-core write data.
- ack  out  NUM_CORES  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data, broadcast; valid for core i when ack[i]=1 and the access was a read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid the cycle after the mem_en read cycle (registered-read memory).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ACCESS, RDWAIT, DONE. All outputs are registered.
- Reset (async) forces:
  - state=IDLE, rr pointer=0, ack=0, rdata=0;
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
  - Reset during any state aborts the transaction with no ack, and mem_en drops immediately.
- IDLE:
  - Masked request vector = req & ~ack, so a core acked this cycle is not re-granted.
  - If the masked vector is nonzero, the winner is the first set bit searching upward from the rr pointer, wrapping mod NUM_CORES.
  - At the clock edge: latch the winner index and we/addr/wdata; rr pointer <= (winner+1) mod NUM_CORES; state -> ACCESS.
- ACCESS (exactly 1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values.
  - Write: next state DONE.
  - Read: next state RDWAIT.
- RDWAIT (1 cycle): mem_en=0; capture rdata <= mem_rdata at the edge; state -> DONE.
- DONE (1 cycle): ack[winner]=1; all other ack bits 0; next state IDLE.
  - rdata holds its value until the next read completes.
- Latency from req sampled in IDLE at cycle t:
  - write ack at cycle t+2;
  - read ack at cycle t+3.
  - The next grant can be sampled in the cycle after DONE.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 transactions.
- Requester protocol:
  - req, we, addr and wdata must be stable from assertion until ack.
  - Deasserting req after the grant edge does not cancel the access; it completes and acks normally.
  - Changes to inputs after the latch edge are ignored.
- Simultaneous requests from all cores are served in rr order starting at the pointer.
- NUM_CORES=1 degenerates to a pure sequencer with the pointer fixed at 0.
- Invariants:
  - ack is at most one-hot.
  - mem_en is high only in ACCESS.
  - mem_we is never high when mem_en is low.

Decomposition:
- Package dm_arb_pkg:
  - state enum (IDLE, ACCESS, RDWAIT, DONE);
  - function clog2 for the index width;
  - localparam IDX_W.
- One sub-module: rr_picker, combinational.
  - Inputs: request vector and pointer.
  - Outputs: valid flag and winner index.
  - Implemented via double-width rotate and priority encode.
  - Unit-testable on its own.

Test Plan:
- Single write: core 2 req, we=1, addr=0x0010, wdata=0xBEEF.
  - mem_en=mem_we=1 with addr 0x0010 and data 0xBEEF in cycle t+1; ack=4'b0100 at t+2.
- Single read: memory model returns 0x1234 for 0x0010; core 1 reads.
  - mem_en=1, mem_we=0 at t+1; ack=4'b0010 and rdata=0x1234 at t+3.
- All four cores request reads simultaneously after reset and hold until acked.
  - Grant order 0,1,2,3; acks spaced 4 cycles apart; no ack overlaps.
- Fairness with the pointer at 1: core 0 and core 3 request continuously.
  - Service order 3,0,3,0; neither core is starved.
- Reset asserted mid-ACCESS of a write.
  - mem_en and mem_we go to 0 asynchronously; no ack follows; the next request after release is granted from pointer 0.
- Core drops req during RDWAIT.
  - The read still completes; ack pulses; the core is not re-granted while its req stays low.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// ============================================================================
// dm_arb_pkg : shared types and sizing for the data-memory arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Index width sized for the largest supported core count.
  localparam int MAX_CORES = 8;
  localparam int IDX_W     = clog2(MAX_CORES);

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_if.sv
// ============================================================================
// dm_arbiter_if : core-side request bus and memory port of the DM arbiter
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface dm_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
);

  logic [NUM_CORES-1:0]    req;
  logic [NUM_CORES-1:0]    we;
  logic [NUM_CORES*AW-1:0] addr;
  logic [NUM_CORES*DW-1:0] wdata;
  logic [NUM_CORES-1:0]    ack;
  logic [DW-1:0]           rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic [DW-1:0]           mem_rdata;
  logic                    busy;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

`default_nettype wire

// File: rtl/dm_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin winner select (rotate + priority enc)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module rr_picker
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0]   rot;
  logic [IDX_W-1:0]       offset;
  logic [IDX_W:0]         sum;

  always_comb begin
    dbl    = {req, req};
    rot    = NUM_CORES'(dbl >> ptr);
    valid  = 1'b0;
    offset = '0;
    // Downward scan so the lowest set bit (closest to the pointer) wins.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid  = 1'b1;
        offset = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(NUM_CORES)) begin
      sum = sum - (IDX_W + 1)'(NUM_CORES);
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// dm_arbiter : round-robin sequencer sharing one single-port DM among cores
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic                 busy_q, busy_d;

  logic [NUM_CORES-1:0] masked_req;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  assign masked_req = bus.req & ~ack_q;

  rr_picker #(
    .NUM_CORES (NUM_CORES)
  ) u_picker (
    .req   (masked_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d    = pick_idx;
          ptr_d    = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + IDX_W'(1);
          mem_en_d = 1'b1;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              mem_we_d    = bus.we[i];
              mem_addr_d  = bus.addr[i*AW +: AW];
              mem_wdata_d = bus.wdata[i*DW +: DW];
            end
          end
          state_d = ACCESS;
          busy_d  = 1'b1;
        end
      end

      ACCESS: begin
        // mem_we_q still holds the latched direction for this cycle.
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (mem_we_q) begin
          state_d = DONE;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (win_q == IDX_W'(i)) ack_d[i] = 1'b1;
          end
        end else begin
          state_d = RDWAIT;
        end
      end

      RDWAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = DONE;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (win_q == IDX_W'(i)) ack_d[i] = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// tb_dm_arbiter : directed bench with a transaction-timeline reference model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_arbiter_if #(.NUM_CORES(N), .AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.NUM_CORES(N), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  // Registered-read memory environment.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a grant starts a timeline; phase counts cycles since grant.
  bit            m_active;
  int            m_phase;
  int            m_win;
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  always @(negedge clk) begin
    logic [N-1:0] e_ack;
    bit           e_en;
    bit           found;
    int           w;
    if (rst) begin
      check("rst_ack",       bus.ack,       0);
      check("rst_busy",      bus.busy,      0);
      check("rst_mem_en",    bus.mem_en,    0);
      check("rst_mem_we",    bus.mem_we,    0);
      check("rst_rdata",     bus.rdata,     0);
      check("rst_mem_addr",  bus.mem_addr,  0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      m_active = 1'b0;
      m_phase  = 0;
      m_ptr    = 0;
      m_rdata  = '0;
    end else begin
      e_ack = '0;
      if (m_active && ((m_we && m_phase == 2) || (!m_we && m_phase == 3))) e_ack[m_win] = 1'b1;
      if (m_active && !m_we && m_phase == 3) m_rdata = ref_mem[m_addr[7:0]];
      e_en = m_active && (m_phase == 1);
      check("ack",    bus.ack,    e_ack);
      check("busy",   bus.busy,   m_active);
      check("mem_en", bus.mem_en, e_en);
      check("mem_we", bus.mem_we, e_en && m_we);
      check("rdata",  bus.rdata,  m_rdata);
      if (e_en) begin
        check("mem_addr",  bus.mem_addr,  m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      if (m_active) begin
        if (m_phase == 1 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
        if ((m_we && m_phase == 2) || (!m_we && m_phase == 3)) m_active = 1'b0;
        else m_phase++;
      end else begin
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && bus.req[(m_ptr + k) % N]) begin
            found = 1'b1;
            w     = (m_ptr + k) % N;
          end
        end
        if (found) begin
          m_active = 1'b1;
          m_phase  = 1;
          m_win    = w;
          m_we     = bus.we[w];
          m_addr   = bus.addr[w*AW +: AW];
          m_wdata  = bus.wdata[w*DW +: DW];
          m_ptr    = (w + 1) % N;
        end
      end
    end
  end

  task automatic drive(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[c]           = 1'b1;
    bus.we[c]            = w;
    bus.addr[c*AW +: AW] = a;
    bus.wdata[c*DW +: DW] = d;
  endtask

  int ord [0:3];
  int at  [0:3];
  int cnt;
  int idx;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = DW'(16'hC000 + i);
      ref_mem[i] = DW'(16'hC000 + i);
    end
    mem[16'h10]     = 16'h1234;
    ref_mem[16'h10] = 16'h1234;
    for (int i = 0; i < N; i++) begin
      mem[8'h20 + i]     = DW'(16'hA000 + i);
      ref_mem[8'h20 + i] = DW'(16'hA000 + i);
    end
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_ack",  bus.ack,  0);
    check("reset_busy", bus.busy, 0);

    // Single read by core 1 of 0x0010.
    drive(1, 1'b0, 16'h0010, 16'h0000);
    tick();
    check("rd_t1_mem_en",   bus.mem_en,   1);
    check("rd_t1_mem_we",   bus.mem_we,   0);
    check("rd_t1_mem_addr", bus.mem_addr, 16'h0010);
    tick();
    check("rd_t2_ack", bus.ack, 4'b0000);
    tick();
    check("rd_t3_ack",   bus.ack,   4'b0010);
    check("rd_t3_rdata", bus.rdata, 16'h1234);
    bus.req[1] = 1'b0;
    tick();

    // Single write by core 2.
    drive(2, 1'b1, 16'h0010, 16'hBEEF);
    tick();
    check("wr_t1_mem_en",    bus.mem_en,    1);
    check("wr_t1_mem_we",    bus.mem_we,    1);
    check("wr_t1_mem_addr",  bus.mem_addr,  16'h0010);
    check("wr_t1_mem_wdata", bus.mem_wdata, 16'hBEEF);
    tick();
    check("wr_t2_ack", bus.ack, 4'b0100);
    bus.req[2] = 1'b0;
    tick();

    // All four cores read at once straight after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 1'b0, AW'(16'h0020 + i), 16'h0000);
    cnt = 0;
    for (int cyc = 1; cyc <= 40 && cnt < 4; cyc++) begin
      tick();
      if (bus.ack != 0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (bus.ack[i]) idx = i;
        ord[cnt] = idx;
        at[cnt]  = cyc;
        cnt++;
        bus.req = bus.req & ~bus.ack;
      end
    end
    bus.req = '0;
    check("all4_count", cnt, 4);
    for (int k = 0; k < 4; k++) begin
      check("all4_order", ord[k], k);
      check("all4_time",  at[k],  3 + 4 * k);
    end
    tick();

    // Move the pointer to 1 with a core-0 write, then cores 0 and 3 compete.
    drive(0, 1'b1, 16'h0030, 16'h0F0F);
    tick();
    tick();
    check("ptr_setup_ack", bus.ack, 4'b0001);
    bus.req[0] = 1'b0;
    tick();
    drive(0, 1'b1, 16'h0031, 16'h1111);
    drive(3, 1'b1, 16'h0033, 16'h3333);
    cnt = 0;
    for (int cyc = 1; cyc <= 40 && cnt < 4; cyc++) begin
      tick();
      if (bus.ack != 0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (bus.ack[i]) idx = i;
        ord[cnt] = idx;
        cnt++;
      end
    end
    bus.req = '0;
    check("fair_count", cnt, 4);
    check("fair_0", ord[0], 3);
    check("fair_1", ord[1], 0);
    check("fair_2", ord[2], 3);
    check("fair_3", ord[3], 0);
    tick();

    // Reset during the ACCESS cycle of a write by core 1.
    drive(1, 1'b1, 16'h0040, 16'h5555);
    tick();
    check("pre_rst_mem_en", bus.mem_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_mem_en", bus.mem_en, 0);
    check("async_mem_we", bus.mem_we, 0);
    check("async_busy",   bus.busy,   0);
    bus.req = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_no_ack", bus.ack, 0);
    end
    drive(0, 1'b1, 16'h0050, 16'h0A0A);
    drive(3, 1'b1, 16'h0053, 16'h3A3A);
    cnt = 0;
    for (int cyc = 1; cyc <= 20 && cnt < 2; cyc++) begin
      tick();
      if (bus.ack != 0) begin
        if (cnt == 0) check("post_rst_first_ack", bus.ack, 4'b0001);
        cnt++;
        bus.req = bus.req & ~bus.ack;
      end
    end
    check("post_rst_count", cnt, 2);
    bus.req = '0;
    tick();

    // Core 2 drops its request while the read is in RDWAIT.
    drive(2, 1'b0, 16'h0010, 16'h0000);
    tick();
    tick();
    bus.req[2] = 1'b0;
    tick();
    check("drop_ack",   bus.ack,   4'b0100);
    check("drop_rdata", bus.rdata, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drop_idle_busy", bus.busy, 0);
      check("drop_idle_ack",  bus.ack,  0);
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
